// File: rtl/ins_mem_pkg.sv
// Shared types and defaults for the instruction memory controller.
package ins_mem_pkg;

    localparam int unsigned DEF_WIDTH = 32'd32;
    localparam int unsigned DEF_DEPTH = 32'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Full 32-bit comparison so high address bits can never alias into the array.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/ins_mem_array.sv
// Instruction storage: one synchronous write port, one enabled synchronous read port, no reset.
module ins_mem_array #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds its last value while re is low
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ins_mem_ctrl.sv
// Instruction memory controller: streamed load FSM (IDLE/LOAD/RUN) and a registered,
// range-checked fetch port in front of ins_mem_array.
module ins_mem_ctrl
    import ins_mem_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    output logic             ld_ready,
    output logic             ld_done,
    input  logic             e,
    input  logic [31:0]      address,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             err
);

    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH - 32'd1);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            q_valid_q, q_valid_d;
    logic            err_q, err_d;
    logic            zero_q, zero_d;

    logic            arr_we_s;
    logic            arr_re_s;
    logic            fetch_s;
    logic            in_range_s;
    logic            restart_s;
    logic [WIDTH-1:0] arr_rdata_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) state_d = ST_LOAD;
                else          state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (ld_valid && (wr_ptr_q == LAST_PTR)) state_d = ST_RUN;
                else                                    state_d = ST_LOAD;
            end
            ST_RUN: begin
                if (ld_start) state_d = ST_LOAD;
                else          state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State decodes: ld_ready/ld_done depend on the state register only
    always_comb begin
        ld_ready  = 1'b0;
        ld_done   = 1'b0;
        arr_we_s  = 1'b0;
        fetch_s   = 1'b0;
        restart_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                restart_s = ld_start;
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                arr_we_s = ld_valid;
            end
            ST_RUN: begin
                ld_done   = 1'b1;
                fetch_s   = e;
                restart_s = ld_start;
            end
            default: begin
                ld_ready = 1'b0;
            end
        endcase
    end

    assign in_range_s = addr_in_range(address, DEPTH);
    assign arr_re_s   = fetch_s & in_range_s;

    // Write pointer and fetch result flags
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        q_valid_d = fetch_s;
        err_d     = fetch_s & ~in_range_s;
        zero_d    = zero_q;
        if (restart_s) begin
            wr_ptr_d = '0;
        end else if (arr_we_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : (wr_ptr_q + AW'(1));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (fetch_s) begin
            zero_d = ~in_range_s;
        end else begin
            zero_d = zero_q;
        end
    end

    // Controller registers; zero_q starts set so q reads 0 out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            q_valid_q <= 1'b0;
            err_q     <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            q_valid_q <= q_valid_d;
            err_q     <= err_d;
            zero_q    <= zero_d;
        end
    end

    ins_mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .waddr (wr_ptr_q),
        .wdata (ld_data),
        .re    (arr_re_s),
        .raddr (address[AW-1:0]),
        .rdata (arr_rdata_s)
    );

    // q is the read register gated by the registered out-of-range flag
    assign q       = zero_q ? '0 : arr_rdata_s;
    assign q_valid = q_valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ins_mem_ctrl.sv
// Scoreboard bench for ins_mem_ctrl: default 32x32 instance plus a 16-bit x 8 instance.
module tb_ins_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] q;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic        rst_a, ld_start_a, ld_valid_a, ld_ready_a, ld_done_a, e_a, q_valid_a, err_a;
    logic [31:0] ld_data_a, address_a, q_a;
    logic        rst_b, ld_start_b, ld_valid_b, ld_ready_b, ld_done_b, e_b, q_valid_b, err_b;
    logic [15:0] ld_data_b, q_b;
    logic [31:0] address_b;

    logic [31:0] img_a [32];
    logic [15:0] img_b [8];

    ins_mem_ctrl u_dut_a (
        .clk(clk), .rst(rst_a), .ld_start(ld_start_a), .ld_valid(ld_valid_a),
        .ld_data(ld_data_a), .ld_ready(ld_ready_a), .ld_done(ld_done_a),
        .e(e_a), .address(address_a), .q(q_a), .q_valid(q_valid_a), .err(err_a)
    );

    ins_mem_ctrl #(.WIDTH(16), .DEPTH(8)) u_dut_b (
        .clk(clk), .rst(rst_b), .ld_start(ld_start_b), .ld_valid(ld_valid_b),
        .ld_data(ld_data_b), .ld_ready(ld_ready_b), .ld_done(ld_done_b),
        .e(e_b), .address(address_b), .q(q_b), .q_valid(q_valid_b), .err(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor for instance A
    always @(negedge clk) begin
        if (q_valid_a === 1'b1) begin
            exp_t x;
            if (qa.size() == 0) begin
                chk("a_unexpected_q_valid", 32'd1, 32'd0);
            end else begin
                x = qa.pop_front();
                chk("a_q", q_a, x.q);
                chk("a_err", {31'd0, err_a}, {31'd0, x.err});
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (q_valid_b === 1'b1) begin
            exp_t x;
            if (qb.size() == 0) begin
                chk("b_unexpected_q_valid", 32'd1, 32'd0);
            end else begin
                x = qb.pop_front();
                chk("b_q", {16'd0, q_b}, x.q);
                chk("b_err", {31'd0, err_b}, {31'd0, x.err});
            end
        end
    end

    task automatic a_fetch(input logic [31:0] addr, input logic [31:0] exp_q, input logic exp_err);
        e_a = 1'b1;
        address_a = addr;
        qa.push_back('{q: exp_q, err: exp_err});
        cyc();
        e_a = 1'b0;
    endtask

    task automatic b_fetch(input logic [31:0] addr, input logic [31:0] exp_q, input logic exp_err);
        e_b = 1'b1;
        address_b = addr;
        qb.push_back('{q: exp_q, err: exp_err});
        cyc();
        e_b = 1'b0;
    endtask

    // Full load of img_a; e held high throughout (must be ignored outside RUN)
    task automatic a_load(input bit gap, input bit fetch_too, input logic [31:0] fetch_exp,
                          input int exp_cycles);
        int n;
        ld_start_a = 1'b1;
        e_a = 1'b1;
        address_a = 32'd1;
        if (fetch_too) qa.push_back('{q: fetch_exp, err: 1'b0});
        cyc();
        ld_start_a = 1'b0;
        address_a = 32'd0;
        chk("a_ld_ready_rise", {31'd0, ld_ready_a}, 32'd1);
        chk("a_ld_done_clear", {31'd0, ld_done_a}, 32'd0);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            ld_valid_a = 1'b1;
            ld_data_a = img_a[i];
            cyc();
            n++;
            if (i < 31) chk("a_ld_done_early", {31'd0, ld_done_a}, 32'd0);
            if (gap && i < 31) begin
                ld_valid_a = 1'b0;
                ld_data_a = 32'hDEADBEEF;
                ld_start_a = 1'b1;
                cyc();
                n++;
                ld_start_a = 1'b0;
            end
        end
        ld_valid_a = 1'b0;
        e_a = 1'b0;
        chk("a_ld_done_set", {31'd0, ld_done_a}, 32'd1);
        chk("a_ld_ready_fall", {31'd0, ld_ready_a}, 32'd0);
        chk("a_load_cycles", n, exp_cycles);
        chk("a_q_valid_in_load", {31'd0, q_valid_a}, 32'd0);
    endtask

    task automatic fill_default();
        img_a[0] = 32'h0F0F0F0E;
        img_a[1] = 32'h0C0C0C0C;
        for (int i = 2; i < 31; i++) img_a[i] = 32'h80000000;
        img_a[31] = 32'hFC0C0C0C;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_a = 1'b1; ld_start_a = 1'b0; ld_valid_a = 1'b0; ld_data_a = 32'd0; e_a = 1'b0; address_a = 32'd0;
        rst_b = 1'b1; ld_start_b = 1'b0; ld_valid_b = 1'b0; ld_data_b = 16'd0; e_b = 1'b0; address_b = 32'd0;
        repeat (2) cyc();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Idle after reset: fetches ignored
        e_a = 1'b1;
        address_a = 32'd0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rst_q", q_a, 32'd0);
            chk("rst_q_valid", {31'd0, q_valid_a}, 32'd0);
            chk("rst_err", {31'd0, err_a}, 32'd0);
            chk("rst_ld_ready", {31'd0, ld_ready_a}, 32'd0);
            chk("rst_ld_done", {31'd0, ld_done_a}, 32'd0);
        end
        e_a = 1'b0;

        // Back-to-back load, then fetch
        fill_default();
        a_load(1'b0, 1'b0, 32'd0, 32);
        a_fetch(32'd0,  32'h0F0F0F0E, 1'b0);
        a_fetch(32'd1,  32'h0C0C0C0C, 1'b0);
        a_fetch(32'd2,  32'h80000000, 1'b0);
        a_fetch(32'd15, 32'h80000000, 1'b0);
        a_fetch(32'd31, 32'hFC0C0C0C, 1'b0);
        cyc();

        // Reload with gaps; the ld_start cycle also fetches address 1 from old contents
        a_load(1'b1, 1'b1, 32'h0C0C0C0C, 63);
        a_fetch(32'd0,  32'h0F0F0F0E, 1'b0);
        a_fetch(32'd1,  32'h0C0C0C0C, 1'b0);
        a_fetch(32'd2,  32'h80000000, 1'b0);
        a_fetch(32'd30, 32'h80000000, 1'b0);
        a_fetch(32'd31, 32'hFC0C0C0C, 1'b0);

        // Out-of-range addresses
        a_fetch(32'd32,         32'd0, 1'b1);
        a_fetch(32'hFFFFFFFF,   32'd0, 1'b1);
        a_fetch(32'h80000001,   32'd0, 1'b1);
        a_fetch(32'h00000040,   32'd0, 1'b1);
        a_fetch(32'd1,  32'h0C0C0C0C, 1'b0);

        // Hold with e=0
        a_fetch(32'd31, 32'hFC0C0C0C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_q", q_a, 32'hFC0C0C0C);
            chk("hold_q_valid", {31'd0, q_valid_a}, 32'd0);
            chk("hold_err", {31'd0, err_a}, 32'd0);
        end

        // Reset in the middle of a load
        ld_start_a = 1'b1;
        cyc();
        ld_start_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ld_valid_a = 1'b1;
            ld_data_a = 32'h11110000 + 32'(i);
            cyc();
        end
        ld_valid_a = 1'b0;
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        chk("midrst_ld_ready", {31'd0, ld_ready_a}, 32'd0);
        chk("midrst_ld_done", {31'd0, ld_done_a}, 32'd0);
        chk("midrst_q", q_a, 32'd0);
        e_a = 1'b1;
        address_a = 32'd0;
        cyc();
        chk("midrst_no_fetch", {31'd0, q_valid_a}, 32'd0);
        e_a = 1'b0;
        for (int i = 0; i < 32; i++) img_a[i] = 32'hA5A5A5A5;
        a_load(1'b0, 1'b0, 32'd0, 32);
        a_fetch(32'd0,  32'hA5A5A5A5, 1'b0);
        a_fetch(32'd9,  32'hA5A5A5A5, 1'b0);
        a_fetch(32'd10, 32'hA5A5A5A5, 1'b0);
        a_fetch(32'd31, 32'hA5A5A5A5, 1'b0);
        cyc();

        // Small instance: WIDTH=16, DEPTH=8
        for (int i = 0; i < 8; i++) img_b[i] = 16'hB000 + 16'(i) * 16'h0111;
        ld_start_b = 1'b1;
        cyc();
        ld_start_b = 1'b0;
        chk("b_ld_ready_rise", {31'd0, ld_ready_b}, 32'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            ld_valid_b = 1'b1;
            ld_data_b = img_b[i];
            cyc();
            n++;
            if (i < 7) chk("b_ld_done_early", {31'd0, ld_done_b}, 32'd0);
        end
        ld_valid_b = 1'b0;
        chk("b_ld_done_set", {31'd0, ld_done_b}, 32'd1);
        chk("b_load_cycles", n, 32'd8);
        b_fetch(32'd0,        32'h0000B000, 1'b0);
        b_fetch(32'd3,        32'h0000B333, 1'b0);
        b_fetch(32'd7,        32'h0000B777, 1'b0);
        b_fetch(32'd8,        32'd0,        1'b1);
        b_fetch(32'hFFFFFFFF, 32'd0,        1'b1);
        b_fetch(32'd5,        32'h0000B555, 1'b0);
        cyc();
        cyc();

        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
